doppler_sweep_ctrl: RTL

Controller that drives the frequency-offset rotator in the channel emulator with a time-varying phase increment, so the emulator can produce a Doppler ramp instead of a fixed offset. The controller steps a signed per-sample phase increment from a start value toward an end value. Each value is held for a programmed number of accepted samples. Output goes straight to the rotator's `phase`/`phase_valid` inputs; sample acceptance comes back from the rotator's output handshake.

---
 rtl/doppler_sweep_pkg.sv | 27 ++
 rtl/sweep_dwell_cnt.sv | 29 ++
 rtl/doppler_sweep_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/doppler_sweep_pkg.sv
// Shared types and constants for the Doppler sweep controller.
// Phase increments are 2Q13 radians, so +/-pi bounds every latched or stepped value.
package doppler_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE   = 2'd0,
        MODE_SAWTOOTH = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    localparam logic signed [15:0] PHASE_MAX = 16'sh6488;
    localparam logic signed [15:0] PHASE_MIN = 16'sh9B78;

    function automatic logic signed [31:0] clamp_phase(input logic signed [31:0] v);
        if (v > 32'(PHASE_MAX)) return 32'(PHASE_MAX);
        if (v < 32'(PHASE_MIN)) return 32'(PHASE_MIN);
        return v;
    endfunction

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Dwell counter: counts accepted samples and flags the tick that completes a dwell.
// The counter self-clears on expiry so the same-cycle tick never carries into the next value.
module sweep_dwell_cnt #(
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               tick,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire = tick && (cnt_q >= dwell - DWELL_W'(1));
        cnt_d  = cnt_q;
        if (clear)       cnt_d = '0;
        else if (expire) cnt_d = '0;
        else if (tick)   cnt_d = cnt_q + DWELL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/doppler_sweep_ctrl.sv
// Steps the rotator's per-sample phase increment from start toward end,
// holding each value for a programmed number of accepted samples.
module doppler_sweep_ctrl
    import doppler_sweep_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int DWELL_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [PHASE_W-1:0] cfg_start_inc,
    input  logic signed [PHASE_W-1:0] cfg_end_inc,
    input  logic signed [PHASE_W-1:0] cfg_step,
    input  logic        [DWELL_W-1:0] cfg_dwell,
    input  logic        [1:0]         cfg_mode,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      sample_tick,
    output logic signed [PHASE_W-1:0] phase,
    output logic                      phase_valid,
    output logic                      busy,
    output logic                      done,
    output logic        [15:0]        step_cnt
);

    state_e                    state_q, state_d;
    mode_e                     mode_q, mode_d;
    logic signed [PHASE_W-1:0] cur_q, cur_d;
    logic signed [PHASE_W-1:0] start_q, start_d;
    logic signed [PHASE_W-1:0] end_q, end_d;
    logic signed [PHASE_W-1:0] step_q, step_d;
    logic        [DWELL_W-1:0] dwell_q, dwell_d;
    logic                      dir_q, dir_d;
    logic                      done_q, done_d;
    logic        [15:0]        step_cnt_q, step_cnt_d;

    logic signed [PHASE_W:0]   eff_step, sum;
    logic signed [PHASE_W-1:0] stepped, target;
    logic                      reached, expire, cnt_clear, cnt_tick;

    assign cnt_clear = start || stop || (state_q != ST_RUN);
    assign cnt_tick  = sample_tick && (state_q == ST_RUN);

    sweep_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .tick   (cnt_tick),
        .dwell  (dwell_q),
        .expire (expire)
    );

    // Going back toward start (triangle) uses the negated step and start as the target.
    always_comb begin
        eff_step = dir_q ? -{step_q[PHASE_W-1], step_q} : {step_q[PHASE_W-1], step_q};
        sum      = {cur_q[PHASE_W-1], cur_q} + eff_step;
        stepped  = PHASE_W'(clamp_phase(32'(sum)));
        target   = dir_q ? start_q : end_q;
        reached  = ((eff_step > 0) && (stepped >= target)) ||
                   ((eff_step < 0) && (stepped <= target));
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cur_d      = cur_q;
        start_d    = start_q;
        end_d      = end_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        if (start) begin
            state_d    = ST_RUN;
            mode_d     = mode_e'(cfg_mode);
            start_d    = PHASE_W'(clamp_phase(32'(cfg_start_inc)));
            end_d      = PHASE_W'(clamp_phase(32'(cfg_end_inc)));
            step_d     = cfg_step;
            dwell_d    = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
            cur_d      = PHASE_W'(clamp_phase(32'(cfg_start_inc)));
            dir_d      = 1'b0;
            step_cnt_d = '0;
        end else if (stop) begin
            state_d = ST_IDLE;
            cur_d   = '0;
            dir_d   = 1'b0;
        end else if (state_q == ST_RUN && expire) begin
            step_cnt_d = (step_cnt_q == 16'hFFFF) ? step_cnt_q : step_cnt_q + 16'd1;
            if (mode_q == MODE_SAWTOOTH && cur_q == end_q) begin
                cur_d = start_q;
            end else if (reached) begin
                cur_d = target;
                case (mode_q)
                    MODE_SAWTOOTH: ;
                    MODE_TRIANGLE: dir_d = ~dir_q;
                    default: begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                cur_d = stepped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SINGLE;
            cur_q      <= '0;
            start_q    <= '0;
            end_q      <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cur_q      <= cur_d;
            start_q    <= start_d;
            end_q      <= end_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign phase       = cur_q;
    assign phase_valid = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign step_cnt    = step_cnt_q;

endmodule
